ibus_seq_master: RTL and testbench
==================================

// Module: ibus_seq_master
// PURPOSE
//  Bus initiator for the systolic iobuf ibus (ren/radr/rdata, wen/wadr/wdata).
//  - Executes host commands: burst-load input buffers from a write stream.
//  - Executes host commands: single register writes (e.g. FFF1 max, FFF2 run, FFF0 start).
//  - Executes host commands: burst-read output buffers into a read stream with backpressure.
//  - Sits between the host-side command/stream logic and iobuf.
// PARAMETERS
//  RD_LAT      1   cycles from ren/ibus_radr registered out to valid ibus_rdata
//  FIFO_DEPTH  4   read-return FIFO entries; must be >= RD_LAT+2
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous active-high reset
//  cmd_valid   in   1   command offered
//  cmd_ready   out  1   command accepted when valid&ready
//  cmd_op      in   2   0=burst write, 1=burst read, 2=reg write, 3=reserved
//  cmd_adr     in   16  start ibus address
//  cmd_len     in   11  word count 0..1024 (bursts only)
//  cmd_data    in   16  data for reg write
//  wd_valid    in   1   write-stream word offered
//  wd_ready    out  1   write-stream word accepted
//  wd_data     in   16  write-stream word
//  rd_valid    out  1   read-stream word available
//  rd_ready    in   1   read-stream consumer ready
//  rd_data     out  16  read-stream word
//  ren         out  1   ibus read strobe
//  ibus_radr   out  16  ibus read address
//  ibus_rdata  in   16  ibus read data
//  wen         out  1   ibus write strobe
//  ibus_wadr   out  16  ibus write address
//  ibus_wdata  out  16  ibus write data
//  busy        out  1   state != IDLE
//  done        out  1   1-cycle pulse at command completion
//  err         out  1   1-cycle pulse with done for op 3 (no bus activity)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters/FIFO cleared; reset mid-burst aborts, no done.
//  All ibus outputs registered; wen/ren high exactly one cycle per word.
//  FSM: IDLE -> WR | RD | REG | FIN.
//  - IDLE: cmd_ready=1; cmd_len==0 on ops 0/1 -> FIN.
//  - WR: wd_ready=1; word accepted at t -> wen, ibus_wadr, ibus_wdata at t+1; after cmd_len words -> FIN.
//  - RD: issues ren when credit available; after cmd_len issued -> DRN.
//  - DRN: waits until FIFO empty and nothing in flight -> FIN.
//  - REG: wen with cmd_adr/cmd_data for one cycle -> FIN.
//  - FIN: done=1 (err=1 if op 3) for one cycle -> IDLE.
//  Address step: adr[9:0] += 1 per word, wraps 3FF->000; adr[15:10] held constant.
//  Read credit: issue only if inflight+fifo_count < FIFO_DEPTH.
//  - Return data pushed into FIFO RD_LAT cycles after ren; FIFO never overflows.
//  - rd_valid = FIFO non-empty; pop on rd_valid&rd_ready; push and pop in same cycle allowed.
//  - Data order equals address order.
//  Commands arriving while busy are held (cmd_ready=0); wd_valid outside WR is ignored.
//  done for WR asserts the cycle after the last wen; for RD, after the last word is popped.
//  wen and ren are never asserted in the same cycle.
// TESTING
//  1. Op0 adr=0000 len=4, wd 11,22,33,44 back-to-back -> wen 4 consecutive cycles; wadr 0000..0003 with matching data; done 1 cycle after.
//  2. Op2 adr=FFF1 data=0008, then op2 FFF0 data=0 -> single wen per cmd; wadr/wdata exact; two done pulses.
//  3. Op1 adr=8000 len=8, rd_ready=1, memory model RD_LAT=1 -> rd_data = mem[8000..8007] in order; done after last pop.
//  4. Op1 len=8 with rd_ready toggled 0/1 randomly -> no loss/duplication; outstanding reads never exceed FIFO_DEPTH.
//  5. Op0 adr=07FE len=4 -> wadr 07FE, 07FF, 0400, 0401 (low-10-bit wrap).
//  6. rst mid op1 after 3 reads; op3; len=0 -> reset: outputs 0, no done; op3: done+err, no bus; len=0: done, no strobes.

Source files
------------

// File: rtl/ibus_seq_master.sv
// ibus initiator: burst writes from a stream, register writes,
// and credit-limited burst reads into a return FIFO.
module ibus_seq_master #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_adr,
  input  logic [10:0] cmd_len,
  input  logic [15:0] cmd_data,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [15:0] wd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] rd_data,
  output logic        ren,
  output logic [15:0] ibus_radr,
  input  logic [15:0] ibus_rdata,
  output logic        wen,
  output logic [15:0] ibus_wadr,
  output logic [15:0] ibus_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE, WR, RD, DRN, REG, FIN
  } state_t;

  state_t state, state_nx;

  logic [15:0] adr;
  logic [10:0] cnt;
  logic        err_q;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fcnt;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [RD_LAT-1:0] rv;

  logic cmd_fire;
  logic reg_fire;
  logic wd_fire;
  logic ren_fire;
  logic credit;
  logic push;
  logic pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cmd_ready = (state == IDLE) & ~rst;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign reg_fire  = cmd_fire & (cmd_op == 2'd2);
  assign wd_ready  = (state == WR) & (cnt != 11'd0);
  assign wd_fire   = wd_valid & wd_ready;

  // Credit covers both reads in flight and words already queued
  assign credit = ({1'b0, inflight} + {1'b0, fcnt})
                  < (CW+1)'(FIFO_DEPTH);
  assign ren_fire = (state == RD) & (cnt != 11'd0) & credit;

  assign push     = rv[RD_LAT-1];
  assign rd_valid = (fcnt != '0);
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = rd_valid ? mem[rp] : 16'd0;

  assign busy = (state != IDLE);
  assign done = (state == FIN);
  assign err  = (state == FIN) & err_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cmd_fire) begin
          unique case (cmd_op)
            2'd0:    state_nx = (cmd_len == 11'd0) ? FIN : WR;
            2'd1:    state_nx = (cmd_len == 11'd0) ? FIN : RD;
            2'd2:    state_nx = REG;
            default: state_nx = FIN;
          endcase
        end
      end
      WR:  if (cnt == 11'd0) state_nx = FIN;
      RD:  if (cnt == 11'd0) state_nx = DRN;
      DRN: if (fcnt == '0 && inflight == '0) state_nx = FIN;
      REG: state_nx = FIN;
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      adr        <= 16'd0;
      cnt        <= 11'd0;
      err_q      <= 1'b0;
      wen        <= 1'b0;
      ibus_wadr  <= 16'd0;
      ibus_wdata <= 16'd0;
      ren        <= 1'b0;
      ibus_radr  <= 16'd0;
      rv         <= '0;
      inflight   <= '0;
      fcnt       <= '0;
      wp         <= '0;
      rp         <= '0;
    end else begin
      state <= state_nx;
      if (cmd_fire) begin
        adr   <= cmd_adr;
        cnt   <= cmd_len;
        err_q <= (cmd_op == 2'd3);
      end else if (wd_fire | ren_fire) begin
        // Only the low 10 bits walk; the buffer select stays put
        adr <= {adr[15:10], adr[9:0] + 10'd1};
        cnt <= cnt - 11'd1;
      end
      wen <= wd_fire | reg_fire;
      if (reg_fire) begin
        ibus_wadr  <= cmd_adr;
        ibus_wdata <= cmd_data;
      end else if (wd_fire) begin
        ibus_wadr  <= adr;
        ibus_wdata <= wd_data;
      end
      ren <= ren_fire;
      if (ren_fire) ibus_radr <= adr;
      rv       <= (rv << 1) | RD_LAT'(ren);
      inflight <= inflight + CW'(ren_fire) - CW'(push);
      fcnt     <= fcnt + CW'(push) - CW'(pop);
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= ibus_rdata;
  end

endmodule

// File: tb/tb_ibus_seq_master.sv
// Scoreboard bench for ibus_seq_master: stimulus queues expected
// bus writes, read words and done pulses; a monitor checks them.
module tb_ibus_seq_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_adr = 16'd0;
  logic [10:0] cmd_len = 11'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        wd_valid = 1'b0;
  logic        wd_ready;
  logic [15:0] wd_data = 16'd0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic        ren;
  logic [15:0] ibus_radr;
  logic [15:0] ibus_rdata = 16'd0;
  logic        wen;
  logic [15:0] ibus_wadr;
  logic [15:0] ibus_wdata;
  logic        busy;
  logic        done;
  logic        err;

  ibus_seq_master #(.RD_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_adr(cmd_adr),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ren(ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
    .wen(wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct packed {
    logic       e;
    logic [1:0] k;
  } dn_t;

  wr_t         wq[$];
  logic [15:0] rq[$];
  dn_t         dq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int outst = 0;
  int ren_cnt = 0;
  int last_wen = 0;
  int last_pop = 0;
  int rd_mode = 0;

  function automatic logic [15:0] memv(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RD_LAT=1 memory: data valid the cycle after ren
  always @(posedge clk) if (ren) ibus_rdata <= memv(ibus_radr);

  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = 1'($urandom_range(0, 1));
      default: rd_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      outst = 0;
    end else begin
      if (wen || ren) begin
        checks++;
        if (wen && ren) begin
          failures++;
          $display("FAIL strobe_excl wen=%b ren=%b required not both",
                   wen, ren);
        end
      end
      if (wen) begin : mon_wen
        wr_t x;
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_wen adr=%h data=%h", ibus_wadr,
                   ibus_wdata);
        end else begin
          x = wq.pop_front();
          if (ibus_wadr !== x.a || ibus_wdata !== x.d) begin
            failures++;
            $display("FAIL wen_word got adr=%h data=%h want adr=%h data=%h",
                     ibus_wadr, ibus_wdata, x.a, x.d);
          end
        end
        last_wen = cyc;
      end
      if (ren) begin
        ren_cnt++;
        checks++;
        if (rq.size() == 0 || outst + 1 > 4) begin
          failures++;
          $display("FAIL ren_credit outstanding=%0d expected_words=%0d want <=4 and >0",
                   outst + 1, rq.size());
        end
        outst++;
      end
      if (rd_valid && rd_ready) begin : mon_rd
        logic [15:0] y;
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rd data=%h", rd_data);
        end else begin
          y = rq.pop_front();
          if (rd_data !== y) begin
            failures++;
            $display("FAIL rd_word got=%h want=%h", rd_data, y);
          end
        end
        outst--;
        last_pop = cyc;
      end
      if (done) begin : mon_done
        dn_t z;
        checks++;
        if (dq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done err=%b", err);
        end else begin
          z = dq.pop_front();
          if (err !== z.e) begin
            failures++;
            $display("FAIL done_err got=%b want=%b", err, z.e);
          end
          if (z.k == 2'd1 && cyc != last_wen + 1) begin
            failures++;
            $display("FAIL wr_done_time got=%0d want=%0d", cyc,
                     last_wen + 1);
          end
          if (z.k == 2'd2 && (rq.size() != 0 || last_pop >= cyc)) begin
            failures++;
            $display("FAIL rd_done_time left=%0d want 0 words left",
                     rq.size());
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] a,
                          input logic [10:0] l, input logic [15:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_adr   = a;
    cmd_len   = l;
    cmd_data  = d;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept got=timeout want=accepted");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_words(input logic [15:0] w[4]);
    int n;
    for (int i = 0; i < 4; i++) begin
      wd_valid = 1'b1;
      wd_data  = w[i];
      n = 0;
      @(negedge clk);
      while (!wd_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        checks++;
        failures++;
        $display("FAIL wd_accept got=timeout want=accepted");
      end
      @(posedge clk);
      #1;
    end
    wd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || dq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL cmd_complete got=timeout want=done pending=%0d",
               dq.size());
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({cmd_ready, wd_ready, rd_valid, rd_data, ren, ibus_radr,
         wen, ibus_wadr, ibus_wdata, busy, done, err} !== '0) begin
      failures++;
      $display("FAIL %s got cmd_ready=%b wd_ready=%b rd_valid=%b ren=%b wen=%b busy=%b done=%b wadr=%h want all 0",
               nm, cmd_ready, wd_ready, rd_valid, ren, wen, busy, done,
               ibus_wadr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] w4[4];
    int n;
    int base;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    wq.push_back({16'h0000, 16'h0011});
    wq.push_back({16'h0001, 16'h0022});
    wq.push_back({16'h0002, 16'h0033});
    wq.push_back({16'h0003, 16'h0044});
    dq.push_back({1'b0, 2'd1});
    send_cmd(2'd0, 16'h0000, 11'd4, 16'h0000);
    w4 = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    send_words(w4);
    wait_done();

    wq.push_back({16'hFFF1, 16'h0008});
    wq.push_back({16'hFFF0, 16'h0000});
    dq.push_back({1'b0, 2'd0});
    dq.push_back({1'b0, 2'd0});
    send_cmd(2'd2, 16'hFFF1, 11'd0, 16'h0008);
    send_cmd(2'd2, 16'hFFF0, 11'd0, 16'h0000);
    wait_done();

    rd_mode = 0;
    for (int i = 0; i < 8; i++) rq.push_back(memv(16'h8000 + 16'(i)));
    dq.push_back({1'b0, 2'd2});
    send_cmd(2'd1, 16'h8000, 11'd8, 16'h0000);
    wait_done();

    rd_mode = 1;
    for (int i = 0; i < 8; i++) rq.push_back(memv(16'h8010 + 16'(i)));
    dq.push_back({1'b0, 2'd2});
    send_cmd(2'd1, 16'h8010, 11'd8, 16'h0000);
    wait_done();
    rd_mode = 0;

    wq.push_back({16'h07FE, 16'h00A1});
    wq.push_back({16'h07FF, 16'h00A2});
    wq.push_back({16'h0400, 16'h00A3});
    wq.push_back({16'h0401, 16'h00A4});
    dq.push_back({1'b0, 2'd1});
    send_cmd(2'd0, 16'h07FE, 11'd4, 16'h0000);
    w4 = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    send_words(w4);
    wait_done();

    rd_mode = 2;
    base = ren_cnt;
    for (int i = 0; i < 8; i++) rq.push_back(memv(16'h8000 + 16'(i)));
    dq.push_back({1'b0, 2'd2});
    send_cmd(2'd1, 16'h8000, 11'd8, 16'h0000);
    n = 0;
    while (ren_cnt < base + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL mid_reads got=%0d want=3", ren_cnt - base);
    end
    rst = 1'b1;
    rq.delete();
    dq.delete();
    @(negedge clk);
    check_zero("mid_reset");
    base = ren_cnt;
    @(negedge clk);
    rst = 1'b0;
    rd_mode = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (ren_cnt != base || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle rens=%0d busy=%b want 0 and 0",
               ren_cnt - base, busy);
    end

    dq.push_back({1'b1, 2'd0});
    send_cmd(2'd3, 16'h1234, 11'd5, 16'h5555);
    wait_done();

    dq.push_back({1'b0, 2'd0});
    send_cmd(2'd0, 16'h0100, 11'd0, 16'h0000);
    wait_done();

    dq.push_back({1'b0, 2'd0});
    send_cmd(2'd1, 16'h8000, 11'd0, 16'h0000);
    wait_done();

    repeat (4) @(negedge clk);
    checks++;
    if (wq.size() != 0 || rq.size() != 0 || dq.size() != 0) begin
      failures++;
      $display("FAIL leftovers got wq=%0d rq=%0d dq=%0d want 0",
               wq.size(), rq.size(), dq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
